// File: rtl/cdclib_lvlsync_tx_sched.sv
// cdclib_lvlsync_tx_sched
// Write-side scheduler sharing one level-synchronized CDC channel among
// NREQ requesters. A round-robin pick captures one payload and drives it
// onto sync_data. After SETUP_CYCLES the toggle-level sync_req flips. The
// block then waits for the returned ack level to match sync_req.
//
// Ports:
//   clk        write-domain clock
//   rst        synchronous reset, active-high
//   req_valid  per-requester transfer request (level)
//   req_data   payloads, requester i at [i*DWIDTH +: DWIDTH]
//   req_done   one-cycle pulse, granted transfer acknowledged
//   req_err    one-cycle pulse, granted transfer timed out
//   sync_data  registered payload to the data level synchronizer
//   sync_req   registered toggle-level request
//   sync_ack   ack level, already synchronized into clk
//   busy       high in any state other than IDLE
//   gnt_id     index of the current or last granted requester
module cdclib_lvlsync_tx_sched #(
  parameter int NREQ           = 4,
  parameter int DWIDTH         = 8,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int IDW           = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_done,
  output logic [NREQ-1:0]        req_err,
  output logic [DWIDTH-1:0]      sync_data,
  output logic                   sync_req,
  input  logic                   sync_ack,
  output logic                   busy,
  output logic [IDW-1:0]         gnt_id
);

  // One counter serves both SETUP and WAIT_ACK; size it for the larger need.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (TW > 8) ? TW : 8;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT_ACK, S_STALL} state_t;

  state_t            r_state;
  logic [DWIDTH-1:0] r_data;
  logic              r_req;
  logic [NREQ-1:0]   r_done;
  logic [NREQ-1:0]   r_err;
  logic [IDW-1:0]    r_gnt_id;
  logic [IDW-1:0]    r_rr_ptr;
  logic [CW-1:0]     r_cnt;

  logic [IDW:0]      w_shl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;
  logic [IDW:0]      w_sum;
  logic [IDW-1:0]    w_pick;
  logic              w_any;
  logic [DWIDTH-1:0] w_pdata;
  logic [NREQ-1:0]   w_gnt_oh;
  logic [IDW-1:0]    w_next_ptr;
  logic              w_ack_match;

  // Rotate req_valid so bit 0 is the rr_ptr requester, find the lowest set
  // bit, then map the offset back to an absolute index modulo NREQ.
  always_comb begin
    w_shl = (IDW+1)'(NREQ) - {1'b0, r_rr_ptr};
    w_rot = (req_valid >> r_rr_ptr) | (req_valid << w_shl);
    w_off = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_rot[NREQ-1-i]) w_off = IDW'(NREQ-1-i);
    end
    w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_pick = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : IDW'(w_sum);
    w_any  = |req_valid;
    w_pdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_pick == IDW'(i)) w_pdata = req_data[i*DWIDTH +: DWIDTH];
    end
  end

  assign w_gnt_oh    = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt_id;
  assign w_next_ptr  = (r_gnt_id == IDW'(NREQ-1)) ? '0 : r_gnt_id + 1'b1;
  assign w_ack_match = (sync_ack == r_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_req    <= 1'b0;
      r_done   <= '0;
      r_err    <= '0;
      r_gnt_id <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt_id <= w_pick;
            r_data   <= w_pdata;
            r_cnt    <= '0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
            r_req   <= ~r_req;
            r_cnt   <= '0;
            r_state <= S_WAIT_ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_ACK: begin
          // Ack match is tested first so it wins over a coincident timeout.
          if (w_ack_match) begin
            r_done   <= w_gnt_oh;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1))) begin
            r_err    <= w_gnt_oh;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_STALL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STALL: begin
          // Absorb the late ack so it is never credited to the next grant.
          if (w_ack_match) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_done  = r_done;
  assign req_err   = r_err;
  assign sync_data = r_data;
  assign sync_req  = r_req;
  assign busy      = (r_state != S_IDLE);
  assign gnt_id    = r_gnt_id;

endmodule

// File: tb/tb_cdclib_lvlsync_tx_sched.sv
module tb_cdclib_lvlsync_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_done;
  logic [3:0]  req_err;
  logic [7:0]  sync_data;
  logic        sync_req;
  logic        sync_ack;
  logic        busy;
  logic [1:0]  gnt_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdclib_lvlsync_tx_sched #(
    .NREQ(4),
    .DWIDTH(8),
    .SETUP_CYCLES(2),
    .TIMEOUT_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_done(req_done),
    .req_err(req_err),
    .sync_data(sync_data),
    .sync_req(sync_req),
    .sync_ack(sync_ack),
    .busy(busy),
    .gnt_id(gnt_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  logic       exp_lvl;
  logic [7:0] slice;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    sync_ack  = 1'b0;
    ticks(2);
    chk("rst_sync_req", 32'(sync_req), 0);
    chk("rst_sync_data", 32'(sync_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_err", 32'(req_err), 0);
    rst = 1'b0;
    tick();

    // Single request from requester 1
    set_data(0, 8'h11); set_data(1, 8'hA5); set_data(2, 8'h33); set_data(3, 8'h44);
    req_valid = 4'b0010;
    tick();                                       // cycle 1
    chk("t1_gnt", 32'(gnt_id), 1);
    chk("t1_data", 32'(sync_data), 32'hA5);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_req_c1", 32'(sync_req), 0);
    tick();                                       // cycle 2
    chk("t1_req_c2", 32'(sync_req), 0);
    tick();                                       // cycle 3
    chk("t1_req_c3", 32'(sync_req), 1);
    ticks(3);                                     // cycle 6
    sync_ack = 1'b1;
    chk("t1_done_c6", 32'(req_done), 0);
    tick();                                       // cycle 7
    chk("t1_done_c7", 32'(req_done), 32'b0010);
    chk("t1_busy_c7", 32'(busy), 0);
    req_valid = 4'b0000;
    tick();
    chk("t1_done_c8", 32'(req_done), 0);

    // Reset from IDLE to put the round-robin pointer back at 0
    rst = 1'b1;
    tick();
    chk("rst2_sync_req", 32'(sync_req), 0);
    rst = 1'b0;
    sync_ack = 1'b0;
    tick();

    // All four requesters held valid: grants 0,1,2,3,0, levels 1,0,1,0,1
    req_valid = 4'b1111;
    exp_lvl = 1'b0;
    for (int t = 0; t < 5; t++) begin
      int g;
      g = t % 4;
      exp_lvl = ~exp_lvl;
      tick();                                     // cycle 1
      slice = req_data[g*8 +: 8];
      chk("rr_gnt", 32'(gnt_id), 32'(g));
      chk("rr_data", 32'(sync_data), 32'(slice));
      chk("rr_done_low", 32'(req_done), 0);
      ticks(2);                                   // cycle 3
      chk("rr_lvl", 32'(sync_req), 32'(exp_lvl));
      ticks(3);                                   // cycle 6
      sync_ack = exp_lvl;
      tick();                                     // cycle 7
      chk("rr_done", 32'(req_done), 32'(4'b0001 << g));
      if (t == 4) req_valid = 4'b0000;
    end
    tick();
    chk("rr_done_width", 32'(req_done), 0);
    chk("rr_idle", 32'(busy), 0);

    // Timeout: requester 3, ack stuck at 1 while sync_req toggles to 0
    set_data(3, 8'hC3);
    req_valid = 4'b1000;
    tick();                                       // cycle 1
    chk("to_gnt", 32'(gnt_id), 3);
    ticks(2);                                     // cycle 3
    chk("to_lvl", 32'(sync_req), 0);
    ticks(4);                                     // cycle 7
    chk("to_err_c7", 32'(req_err), 0);
    tick();                                       // cycle 8
    chk("to_err_c8", 32'(req_err), 32'b1000);
    chk("to_done_c8", 32'(req_done), 0);
    chk("to_busy_c8", 32'(busy), 1);
    req_valid = 4'b0000;
    tick();                                       // cycle 9
    chk("to_err_c9", 32'(req_err), 0);
    chk("to_stall_busy", 32'(busy), 1);
    tick();                                       // cycle 10
    chk("to_stall_data", 32'(sync_data), 32'hC3);
    chk("to_stall_req", 32'(sync_req), 0);
    sync_ack = 1'b0;
    tick();                                       // cycle 11
    chk("to_idle_busy", 32'(busy), 0);
    chk("to_idle_done", 32'(req_done), 0);
    chk("to_idle_err", 32'(req_err), 0);

    // Ack match on the timeout cycle: done wins
    set_data(0, 8'h5A);
    req_valid = 4'b0001;
    tick();                                       // cycle 1
    chk("same_gnt", 32'(gnt_id), 0);
    ticks(2);                                     // cycle 3
    chk("same_lvl", 32'(sync_req), 1);
    ticks(4);                                     // cycle 7
    sync_ack = 1'b1;
    tick();                                       // cycle 8
    chk("same_done", 32'(req_done), 32'b0001);
    chk("same_err", 32'(req_err), 0);
    chk("same_busy", 32'(busy), 0);
    req_valid = 4'b0000;
    tick();
    chk("same_err_after", 32'(req_err), 0);

    // Reset during WAIT_ACK
    set_data(2, 8'h77);
    req_valid = 4'b0100;
    tick();                                       // cycle 1
    chk("rw_gnt", 32'(gnt_id), 2);
    ticks(2);                                     // cycle 3
    chk("rw_lvl", 32'(sync_req), 0);
    tick();                                       // cycle 4
    rst = 1'b1;
    tick();                                       // cycle 5
    chk("rw_sync_req", 32'(sync_req), 0);
    chk("rw_sync_data", 32'(sync_data), 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_done", 32'(req_done), 0);
    chk("rw_err", 32'(req_err), 0);
    rst = 1'b0;
    req_valid = 4'b1001;
    tick();                                       // cycle 6
    chk("rw_regrant", 32'(gnt_id), 0);
    chk("rw_regrant_data", 32'(sync_data), 32'h5A);
    req_valid = 4'b0000;
    tick();                                       // cycle 7, ack=1 ignored in SETUP
    chk("rw_setup_req", 32'(sync_req), 0);
    chk("rw_setup_done", 32'(req_done), 0);
    tick();                                       // cycle 8
    chk("rw_lvl2", 32'(sync_req), 1);
    tick();                                       // cycle 9
    chk("rw_done2", 32'(req_done), 32'b0001);

    // Requester drops valid and changes data after grant
    set_data(1, 8'h3C);
    req_valid = 4'b0010;
    tick();                                       // cycle 1
    chk("drop_gnt", 32'(gnt_id), 1);
    req_valid = 4'b0000;
    set_data(1, 8'hFF);
    tick();                                       // cycle 2
    chk("drop_data_c2", 32'(sync_data), 32'h3C);
    tick();                                       // cycle 3
    chk("drop_lvl", 32'(sync_req), 0);
    ticks(2);                                     // cycle 5
    sync_ack = 1'b0;
    tick();                                       // cycle 6
    chk("drop_done", 32'(req_done), 32'b0010);
    chk("drop_data_c6", 32'(sync_data), 32'h3C);
    chk("drop_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
